// File: rtl/first_counter_monitor.sv
// Watches a free-running counter and its overflow flag, predicts each sample
// from the previous one, and reports mismatches, fault state and statistics.
module first_counter_monitor #(
    parameter int          CNT_W     = 4,
    parameter int unsigned ERR_LIMIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dut_reset,
    input  logic [CNT_W-1:0] counter_in,
    input  logic             overflow_in,
    input  logic             clear,
    output logic             locked_out,
    output logic             mismatch_out,
    output logic             fault_out,
    output logic [7:0]       err_count_out,
    output logic [7:0]       wrap_count_out,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [7:0]       LIMIT   = 8'(ERR_LIMIT);
    localparam logic [7:0]       SAT     = 8'hFF;

    state_t           state, state_n;
    logic             prev_en, prev_rst;
    logic [CNT_W-1:0] prev_cnt;
    logic [7:0]       err_count, err_n;
    logic [7:0]       wrap_count, wrap_n;
    logic             mismatch, mismatch_n;

    logic [CNT_W-1:0] exp_cnt;
    logic             exp_ovf;
    logic             error;

    // Prediction is built only from the previous sample, never from our own history.
    always_comb begin
        exp_cnt = prev_cnt;
        if (prev_rst) begin
            exp_cnt = '0;
        end else if (prev_en) begin
            exp_cnt = prev_cnt + CNT_W'(1);
        end
        exp_ovf = !prev_rst && prev_en && (prev_cnt == CNT_MAX);
        error   = (state != IDLE) &&
                  ((counter_in != exp_cnt) || (overflow_in != exp_ovf));
    end

    always_comb begin
        state_n    = state;
        err_n      = err_count;
        wrap_n     = wrap_count;
        mismatch_n = 1'b0;
        if (clear) begin
            state_n = IDLE;
            err_n   = '0;
            wrap_n  = '0;
        end else begin
            case (state)
                IDLE: state_n = TRACK;
                TRACK, FAULT: begin
                    if (error) begin
                        mismatch_n = 1'b1;
                        if (err_count != SAT) begin
                            err_n = err_count + 8'd1;
                        end
                    end
                    if (overflow_in && exp_ovf && (wrap_count != SAT)) begin
                        wrap_n = wrap_count + 8'd1;
                    end
                    if ((state == TRACK) && error && (err_n >= LIMIT)) begin
                        state_n = FAULT;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            prev_en    <= 1'b0;
            prev_rst   <= 1'b0;
            prev_cnt   <= '0;
            err_count  <= '0;
            wrap_count <= '0;
            mismatch   <= 1'b0;
        end else begin
            state      <= state_n;
            prev_en    <= enable;
            prev_rst   <= dut_reset;
            prev_cnt   <= counter_in;
            err_count  <= err_n;
            wrap_count <= wrap_n;
            mismatch   <= mismatch_n;
        end
    end

    assign locked_out     = (state != IDLE);
    assign fault_out      = (state == FAULT);
    assign mismatch_out   = mismatch;
    assign err_count_out  = err_count;
    assign wrap_count_out = wrap_count;
    assign dbg_state      = state;

endmodule

// File: tb/tb_first_counter_monitor.sv
// Directed bench for first_counter_monitor: a vector table plus hand-written
// multi-cycle sequences for lock, hold, clear, saturation and async reset.
module tb_first_counter_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       dut_reset = 1'b0;
    logic [3:0] counter_in = 4'd0;
    logic       overflow_in = 1'b0;
    logic       clear = 1'b0;
    logic       locked_out, mismatch_out, fault_out;
    logic [7:0] err_count_out, wrap_count_out;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side model of a correctly behaving counter.
    logic [3:0] m_cnt = 4'd0;
    logic       m_ovf = 1'b0;

    typedef struct {
        logic       en, rst;
        logic [3:0] cnt;
        logic       ovf, clr;
        logic       mm, lk, ft;
        logic [7:0] err, wrap;
    } vec_t;

    vec_t tbl[33];

    first_counter_monitor #(.CNT_W(4), .ERR_LIMIT(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .dut_reset(dut_reset),
        .counter_in(counter_in), .overflow_in(overflow_in), .clear(clear),
        .locked_out(locked_out), .mismatch_out(mismatch_out), .fault_out(fault_out),
        .err_count_out(err_count_out), .wrap_count_out(wrap_count_out),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one sample, let one rising edge pass, return on the following negedge.
    task automatic cyc(input logic en, input logic rst, input logic [3:0] cnt,
                       input logic ovf, input logic clr);
        enable = en; dut_reset = rst; counter_in = cnt; overflow_in = ovf; clear = clr;
        @(negedge clk);
        m_ovf = !rst && en && (cnt == 4'd15);
        m_cnt = rst ? 4'd0 : (en ? cnt + 4'd1 : cnt);
    endtask

    task automatic good(input logic en, input logic rst);
        cyc(en, rst, m_cnt, m_ovf, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " locked"},   {7'd0, locked_out},   8'd0);
        check({tag, " mismatch"}, {7'd0, mismatch_out}, 8'd0);
        check({tag, " fault"},    {7'd0, fault_out},    8'd0);
        check({tag, " err"},      err_count_out,        8'd0);
        check({tag, " wrap"},     wrap_count_out,       8'd0);
    endtask

    function automatic vec_t mk(input int en, rst, cnt, ovf, clr, mm, lk, ft, err, wrap);
        vec_t v;
        v.en = en[0]; v.rst = rst[0]; v.cnt = cnt[3:0]; v.ovf = ovf[0]; v.clr = clr[0];
        v.mm = mm[0]; v.lk = lk[0]; v.ft = ft[0]; v.err = err[7:0]; v.wrap = wrap[7:0];
        return v;
    endfunction

    initial begin
        //            en rst cnt ovf clr | mm lk ft err wrap
        tbl[0]  = mk(0, 1, 0,  0, 0,   0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0,  0, 0,   0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 1,  0, 0,   0, 1, 0, 0, 0);
        tbl[3]  = mk(1, 0, 2,  0, 0,   0, 1, 0, 0, 0);
        tbl[4]  = mk(1, 0, 3,  0, 0,   0, 1, 0, 0, 0);
        tbl[5]  = mk(1, 0, 4,  0, 0,   0, 1, 0, 0, 0);
        tbl[6]  = mk(1, 0, 5,  0, 0,   0, 1, 0, 0, 0);
        tbl[7]  = mk(1, 0, 7,  0, 0,   1, 1, 1, 1, 0);
        tbl[8]  = mk(1, 0, 8,  0, 0,   0, 1, 1, 1, 0);
        for (int i = 9; i <= 15; i++) tbl[i] = mk(1, 0, i, 0, 0, 0, 1, 1, 1, 0);
        tbl[16] = mk(1, 0, 0,  0, 0,   1, 1, 1, 2, 0);
        tbl[17] = mk(1, 0, 1,  0, 0,   0, 1, 1, 2, 0);
        tbl[18] = mk(1, 0, 2,  0, 0,   0, 1, 1, 2, 0);
        tbl[19] = mk(1, 0, 3,  0, 0,   0, 1, 1, 2, 0);
        tbl[20] = mk(1, 0, 4,  1, 0,   1, 1, 1, 3, 0);
        tbl[21] = mk(0, 0, 5,  0, 0,   0, 1, 1, 3, 0);
        tbl[22] = mk(0, 0, 5,  0, 0,   0, 1, 1, 3, 0);
        tbl[23] = mk(0, 0, 6,  0, 0,   1, 1, 1, 4, 0);
        tbl[24] = mk(1, 0, 9,  0, 1,   0, 0, 0, 0, 0);
        tbl[25] = mk(1, 0, 0,  0, 0,   0, 1, 0, 0, 0);
        tbl[26] = mk(1, 0, 1,  0, 0,   0, 1, 0, 0, 0);
        tbl[27] = mk(1, 0, 5,  0, 0,   1, 1, 1, 1, 0);
        tbl[28] = mk(1, 1, 6,  0, 0,   0, 1, 1, 1, 0);
        tbl[29] = mk(1, 0, 0,  0, 0,   0, 1, 1, 1, 0);
        tbl[30] = mk(1, 0, 1,  0, 0,   0, 1, 1, 1, 0);
        tbl[31] = mk(1, 0, 15, 0, 0,   1, 1, 1, 2, 0);
        tbl[32] = mk(1, 0, 0,  1, 0,   0, 1, 1, 2, 1);

        // Reset state while reset is held.
        @(negedge clk);
        check_all_zero("reset");
        check("reset state", {6'd0, dbg_state}, 8'd0);

        // Correct counter: one dut_reset cycle, then 100 enabled cycles.
        do_reset();
        good(1'b0, 1'b1);
        for (int i = 0; i < 100; i++) good(1'b1, 1'b0);
        check("run locked", {7'd0, locked_out}, 8'd1);
        check("run err",    err_count_out,      8'd0);
        check("run wrap",   wrap_count_out,     8'd6);
        check("run fault",  {7'd0, fault_out},  8'd0);

        // Vector table: skip, missing/spurious overflow, hold, clear vs error.
        do_reset();
        for (int i = 0; i < 33; i++) begin
            cyc(tbl[i].en, tbl[i].rst, tbl[i].cnt, tbl[i].ovf, tbl[i].clr);
            check($sformatf("vec%0d mismatch", i), {7'd0, mismatch_out}, {7'd0, tbl[i].mm});
            check($sformatf("vec%0d locked", i),   {7'd0, locked_out},   {7'd0, tbl[i].lk});
            check($sformatf("vec%0d fault", i),    {7'd0, fault_out},    {7'd0, tbl[i].ft});
            check($sformatf("vec%0d err", i),      err_count_out,        tbl[i].err);
            check($sformatf("vec%0d wrap", i),     wrap_count_out,       tbl[i].wrap);
        end

        // Hold while disabled for 20 cycles, then a change with enable low.
        do_reset();
        cyc(1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
        check("hold err",   err_count_out,     8'd0);
        check("hold fault", {7'd0, fault_out}, 8'd0);
        cyc(1'b0, 1'b0, 4'd10, 1'b0, 1'b0);
        check("hold change mismatch", {7'd0, mismatch_out}, 8'd1);
        check("hold change err",      err_count_out,        8'd1);
        cyc(1'b0, 1'b0, 4'd10, 1'b0, 1'b0);
        check("hold pulse end", {7'd0, mismatch_out}, 8'd0);
        check("hold err kept",  err_count_out,        8'd1);

        // Clear from FAULT returns to IDLE, next edge re-locks.
        cyc(1'b0, 1'b0, 4'd10, 1'b0, 1'b1);
        check("clear state",  {6'd0, dbg_state}, 8'd0);
        check("clear err",    err_count_out,     8'd0);
        cyc(1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
        check("relock state", {6'd0, dbg_state}, 8'd1);
        check("relock err",   err_count_out,     8'd0);

        // Error-count saturation, then asynchronous mid-run reset.
        do_reset();
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b0, (i % 2 == 0) ? 4'd1 : 4'd0, 1'b0, 1'b0);
        check("sat err",      err_count_out,        8'd255);
        check("sat fault",    {7'd0, fault_out},    8'd1);
        check("sat mismatch", {7'd0, mismatch_out}, 8'd1);
        #2 reset = 1'b1;
        #1 check_all_zero("async reset");
        @(negedge clk);
        reset = 1'b0;

        // Wrap-count saturation with a correct counter.
        good(1'b0, 1'b1);
        for (int i = 0; i < 16 * 256 + 8; i++) good(1'b1, 1'b0);
        check("wrap sat",     wrap_count_out, 8'd255);
        check("wrap sat err", err_count_out,  8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
